sb_tx_arbiter: RTL
==================

Name: sb_tx_arbiter

Overview:
- Shares the single sideband TX message port (serializer input) among NUM_REQ LTSM substate controllers, e.g. SBINIT, MBINIT, MBTRAIN.
- Round-robin arbitration per message; latches the granted message and presents it to the serializer until accepted.
- Owns one retry timer per requester and pulses that requester's retry flag when no response clears it in time.
- Sits between the LTSM substate blocks and the SB serializer, clocked in the 100 MHz sideband domain.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- RETRY_CYCLES, 800, retry interval in clk_100MHz cycles (8 us); must be >= 2.
- GAP_CYCLES, 2, minimum idle cycles between consecutive tx_valid_o assertions; must be >= 1.

Ports:
- clk_100MHz  in  1  sideband clock, all logic on posedge.
- reset  in  1  asynchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester message request (level).
- req_msg_i  in  NUM_REQ x SB_msg_t  message per requester; must be stable while req_valid_i is high.
- req_data_i  in  NUM_REQ x 64  data per requester; must be stable while req_valid_i is high.
- req_ack_o  out  NUM_REQ  one-cycle pulse: requester's message accepted by serializer.
- retry_timeout_o  out  NUM_REQ  one-cycle pulse: retry interval expired.
- clear_retry_i  in  NUM_REQ  disarms the requester's retry timer (expected response received).
- tx_msg_o  out  SB_msg_t  message to serializer.
- tx_data_o  out  64  data to serializer.
- tx_valid_o  out  1  message valid.
- tx_sendNext_i  in  1  serializer ready / accept strobe.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: tx_valid_o=0, tx_msg_o=reset_SB_msg(), tx_data_o=0, req_ack_o=0, retry_timeout_o=0, busy_o=0.
- Reset internals: state=IDLE, last_grant=NUM_REQ-1, all timers disarmed. Reset mid-operation aborts any message immediately with no ack.
- FSM states:
  - IDLE: at a posedge with any req_valid_i high, grant the first valid index searching from last_grant+1 with wrap-around. Latch req_msg_i/req_data_i into tx_msg_o/tx_data_o, set tx_valid_o=1, update last_grant, go to SEND. Latency is 1 cycle from valid sampled to tx_valid_o high.
  - SEND: hold tx_valid_o, tx_msg_o and tx_data_o constant. At the posedge where tx_sendNext_i=1, the message is accepted: tx_valid_o<=0, req_ack_o[grant]<=1 for one cycle, arm/restart timer[grant], go to GAP.
  - GAP: count GAP_CYCLES cycles (tx_sendNext_i ignored), then go to IDLE. Arbitration restarts only in IDLE.
- In IDLE, tx_sendNext_i is ignored.
- If req_valid_i[grant] drops during SEND, the latched message is still sent and still acked.
- A requester re-asserting valid right after its ack gets its turn only after the other pending requesters (round-robin fairness).
- Retry timer i, counter width $clog2(RETRY_CYCLES):
  - Armed (count=0) on ack of i.
  - Increments each cycle while armed.
  - At count==RETRY_CYCLES-1, pulses retry_timeout_o[i] and disarms. The pulse occurs RETRY_CYCLES cycles after the ack pulse.
  - clear_retry_i[i] disarms with no pulse.
  - Simultaneous ack and clear on the same timer: ack wins (re-arm at 0).
  - Simultaneous terminal count and clear: clear wins, no pulse.
  - Timers are independent; several may pulse in the same cycle.
- busy_o = (state != IDLE).

Optional Feature:
- Macro SB_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins in IDLE; last_grant is unused.
- Undefined: round-robin as above.
- Timers, handshake and latencies are identical in both builds.

Decomposition:
- SB_codex_pkg: existing SB_msg_t and reset_SB_msg(); add sb_arb_state_t enum {IDLE, SEND, GAP} and localparam SB_RETRY_8US = 800.
- Sub-module sb_retry_timer (RETRY_CYCLES parameter; arm_i, clear_i, timeout_o), instantiated NUM_REQ times via generate.

Test Plan:
- Reset sanity: reset during SEND with tx_valid_o=1 → outputs return to reset values asynchronously; no req_ack_o pulse after release.
- Single request: req_valid_i=4'b0001, tx_sendNext_i tied 1 → tx_valid_o high 1 cycle after valid; req_ack_o=4'b0001 pulse; next tx_valid_o no earlier than GAP_CYCLES=2 idle cycles later.
- Round-robin: req_valid_i=4'b1011 held, sendNext always 1 → grant order 0,1,3,0,1,3. With SB_TX_ARB_FIXED_PRIO_EN the grant is always 0.
- Backpressure: tx_sendNext_i=0 for 20 cycles → tx_msg_o/tx_data_o unchanged, no ack; sendNext=1 → exactly one ack.
- Retry: ack requester 2, no clear → retry_timeout_o[2] pulses exactly 800 cycles after the ack pulse. Repeat with clear_retry_i[2] at cycle 500 → no pulse.
- Collision: clear_retry_i[1] asserted in the same cycle as ack[1] → timer re-armed, pulse after 800 cycles.

Source files
------------

// File: rtl/SB_codex_pkg.sv
// Shared sideband codec types: the SB message record, its reset value and the
// TX arbiter state encoding.
package SB_codex_pkg;

   typedef struct packed {
      logic [4:0]  opcode;
      logic [7:0]  msg_code;
      logic [7:0]  msg_subcode;
      logic [15:0] msg_info;
      logic [1:0]  src_id;
   } SB_msg_t;

   typedef enum logic [1:0] {IDLE, SEND, GAP} sb_arb_state_t;

   localparam int SB_RETRY_8US = 800;

   // Opcode all-ones marks "no message" on an idle serializer input.
   function automatic SB_msg_t reset_SB_msg();
      SB_msg_t m;
      m        = '0;
      m.opcode = 5'h1F;
      return m;
   endfunction

endpackage

// File: rtl/sb_tx_arbiter_if.sv
// Request/serializer bundle between the LTSM substate controllers, the TX
// arbiter (slave) and whatever drives the requests (master).
interface sb_tx_arbiter_if
   import SB_codex_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]       req_valid_i;
   SB_msg_t [NUM_REQ-1:0]    req_msg_i;
   logic [NUM_REQ-1:0][63:0] req_data_i;
   logic [NUM_REQ-1:0]       req_ack_o;
   logic [NUM_REQ-1:0]       retry_timeout_o;
   logic [NUM_REQ-1:0]       clear_retry_i;
   SB_msg_t                  tx_msg_o;
   logic [63:0]              tx_data_o;
   logic                     tx_valid_o;
   logic                     tx_sendNext_i;
   logic                     busy_o;

   modport slave (
      input  req_valid_i, req_msg_i, req_data_i, clear_retry_i, tx_sendNext_i,
      output req_ack_o, retry_timeout_o, tx_msg_o, tx_data_o, tx_valid_o, busy_o
   );

   modport master (
      output req_valid_i, req_msg_i, req_data_i, clear_retry_i, tx_sendNext_i,
      input  req_ack_o, retry_timeout_o, tx_msg_o, tx_data_o, tx_valid_o, busy_o
   );
endinterface

// File: rtl/sb_retry_timer.sv
// Per-requester retry timer: armed by an ack, pulses timeout_o RETRY_CYCLES
// cycles later unless cleared first. Arm beats clear; clear beats terminal count.
module sb_retry_timer #(
   parameter int RETRY_CYCLES = 800
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic arm_i,
   input  logic clear_i,
   output logic timeout_o
);
   localparam int CW = $clog2(RETRY_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(RETRY_CYCLES - 1);

   logic          armed_q, armed_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;

   always_comb begin
      armed_d   = armed_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      if (arm_i) begin
         armed_d = 1'b1;
         cnt_d   = '0;
      end else if (clear_i) begin
         armed_d = 1'b0;
      end else if (armed_q) begin
         if (cnt_q == TERM) begin
            timeout_d = 1'b1;
            armed_d   = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         armed_q   <= 1'b0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         armed_q   <= armed_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
endmodule

// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: grants one requester per message onto the serializer port
// and owns a retry timer per requester. Define SB_TX_ARB_FIXED_PRIO_EN for
// fixed lowest-index priority instead of round-robin.
module sb_tx_arbiter
   import SB_codex_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int RETRY_CYCLES = SB_RETRY_8US,
   parameter int GAP_CYCLES   = 2
) (
   input logic            clk_100MHz,
   input logic            reset,
   sb_tx_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   sb_arb_state_t      state_q, state_d;
   logic [IW-1:0]      grant_q, grant_d;
   logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
   SB_msg_t            tx_msg_q, tx_msg_d;
   logic [63:0]        tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [NUM_REQ-1:0] timeout;
   logic [IW-1:0]      pick;

`ifdef SB_TX_ARB_FIXED_PRIO_EN
   always_comb begin
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid_i[k]) pick = IW'(k);
      end
   end
`else
   logic [IW-1:0] last_grant_q, last_grant_d;
   logic [IW-1:0] cand;
   logic          found;

   // Search starts just after the previous winner so every pending requester is served in turn.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((int'(last_grant_q) + k) % NUM_REQ);
         if (!found && bus.req_valid_i[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == IDLE && |bus.req_valid_i) last_grant_d = pick;
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) last_grant_q <= IW'(NUM_REQ - 1);
      else       last_grant_q <= last_grant_d;
   end
`endif

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gap_cnt_d  = gap_cnt_q;
      tx_msg_d   = tx_msg_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      ack_d      = '0;
      case (state_q)
         IDLE: begin
            if (|bus.req_valid_i) begin
               grant_d    = pick;
               tx_msg_d   = bus.req_msg_i[pick];
               tx_data_d  = bus.req_data_i[pick];
               tx_valid_d = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (bus.tx_sendNext_i) begin
               tx_valid_d     = 1'b0;
               ack_d[grant_q] = 1'b1;
               gap_cnt_d      = '0;
               state_d        = GAP;
            end
         end
         GAP: begin
            if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
            else                                  gap_cnt_d = gap_cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         gap_cnt_q  <= '0;
         tx_msg_q   <= reset_SB_msg();
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         ack_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gap_cnt_q  <= gap_cnt_d;
         tx_msg_q   <= tx_msg_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         ack_q      <= ack_d;
      end
   end

   // The accept decision arms the timer on the same edge that registers the ack pulse.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_timer
      sb_retry_timer #(.RETRY_CYCLES(RETRY_CYCLES)) u_timer (
         .clk_100MHz (clk_100MHz),
         .reset      (reset),
         .arm_i      (ack_d[gi]),
         .clear_i    (bus.clear_retry_i[gi]),
         .timeout_o  (timeout[gi])
      );
   end

   assign bus.tx_msg_o        = tx_msg_q;
   assign bus.tx_data_o       = tx_data_q;
   assign bus.tx_valid_o      = tx_valid_q;
   assign bus.req_ack_o       = ack_q;
   assign bus.retry_timeout_o = timeout;
   assign bus.busy_o          = (state_q != IDLE);
endmodule
